// File: rtl/gc_pkg.sv
// Shared constants and types for the garbled-circuit gate sequencer.
package gc_pkg;

  localparam int WIRE_ID_W = 24;
  localparam int LABEL_W   = 128;

  localparam logic [1:0] AND_GATE = 2'd0;
  localparam logic [1:0] XOR_GATE = 2'd1;
  localparam logic [1:0] BUF_GATE = 2'd2;
  localparam logic [1:0] BAD_GATE = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_NEXT,
    S_F1,
    S_W1,
    S_F2,
    S_W2,
    S_EV,
    S_WEV,
    S_ST,
    S_WST
  } state_t;

endpackage

// File: rtl/gate_seq.sv
// Walks a gate list: fetches input labels, evaluates AND gates,
// and stores the output label of each gate.
module gate_seq
  import gc_pkg::*;
#(
  parameter int WIRE_ID_W = gc_pkg::WIRE_ID_W,
  parameter int LABEL_W   = gc_pkg::LABEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIRE_ID_W-1:0] num_gates,
  output logic                 busy,
  output logic                 circuit_done,
  output logic                 err_gate,
  input  logic                 gd_valid,
  output logic                 gd_ready,
  input  logic [1:0]           gd_type,
  input  logic [WIRE_ID_W-1:0] gd_in1,
  input  logic [WIRE_ID_W-1:0] gd_in2,
  input  logic [WIRE_ID_W-1:0] gd_out,
  output logic [WIRE_ID_W-1:0] wire_id_read,
  output logic                 id_1_strobe,
  output logic                 id_2_strobe,
  output logic [1:0]           gate_type,
  input  logic                 lc_done,
  input  logic [LABEL_W-1:0]   lc_label,
  input  logic [1:0]           lc_ptr,
  output logic [WIRE_ID_W-1:0] wire_id_write,
  output logic                 store_strobe,
  output logic [LABEL_W-1:0]   label_store,
  output logic                 eval_req,
  output logic [LABEL_W-1:0]   eval_label,
  output logic [1:0]           eval_ptr,
  input  logic                 eval_done,
  input  logic [LABEL_W-1:0]   eval_result,
  output logic                 lc_rst
);

  state_t               r_state;
  logic [WIRE_ID_W-1:0] r_num;
  logic [WIRE_ID_W-1:0] r_cnt;
  logic [WIRE_ID_W-1:0] r_in2;
  logic [WIRE_ID_W-1:0] r_out;
  logic [LABEL_W-1:0]   r_lab1;
  logic [1:0]           r_rst_sync;

  logic [WIRE_ID_W-1:0] w_cnt_inc;
  logic                 w_is_and;
  logic                 w_is_xor;
  logic                 w_is_buf;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_is_and  = (gate_type == AND_GATE);
  assign w_is_xor  = (gate_type == XOR_GATE);
  assign w_is_buf  = (gate_type == BUF_GATE);

  // Label controller reset: asserted at once, released two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign lc_rst = r_rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_num         <= '0;
      r_cnt         <= '0;
      r_in2         <= '0;
      r_out         <= '0;
      r_lab1        <= '0;
      busy          <= 1'b0;
      circuit_done  <= 1'b0;
      err_gate      <= 1'b0;
      gd_ready      <= 1'b0;
      wire_id_read  <= '0;
      id_1_strobe   <= 1'b0;
      id_2_strobe   <= 1'b0;
      gate_type     <= '0;
      wire_id_write <= '0;
      store_strobe  <= 1'b0;
      label_store   <= '0;
      eval_req      <= 1'b0;
      eval_label    <= '0;
      eval_ptr      <= '0;
    end else begin
      id_1_strobe  <= 1'b0;
      id_2_strobe  <= 1'b0;
      store_strobe <= 1'b0;
      eval_req     <= 1'b0;
      circuit_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num    <= num_gates;
            r_cnt    <= '0;
            busy     <= 1'b1;
            gd_ready <= (num_gates != '0);
            r_state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_cnt == r_num) begin
            circuit_done <= 1'b1;
            busy         <= 1'b0;
            gd_ready     <= 1'b0;
            r_state      <= S_IDLE;
          end else if (gd_valid && gd_ready) begin
            r_in2 <= gd_in2;
            r_out <= gd_out;
            if (gd_type == BAD_GATE) begin
              // Skip the gate but count it so the circuit still ends.
              err_gate <= 1'b1;
              r_cnt    <= w_cnt_inc;
              gd_ready <= (w_cnt_inc != r_num);
            end else begin
              gd_ready     <= 1'b0;
              gate_type    <= gd_type;
              wire_id_read <= gd_in1;
              id_1_strobe  <= 1'b1;
              r_state      <= S_F1;
            end
          end else begin
            gd_ready <= 1'b1;
          end
        end
        S_F1: begin
          r_state <= S_W1;
        end
        S_W1: begin
          if (lc_done) begin
            r_lab1 <= lc_label;
            unique case (1'b1)
              w_is_buf: begin
                label_store   <= lc_label;
                wire_id_write <= r_out;
                store_strobe  <= 1'b1;
                r_state       <= S_ST;
              end
              default: begin
                wire_id_read <= r_in2;
                id_2_strobe  <= 1'b1;
                r_state      <= S_F2;
              end
            endcase
          end
        end
        S_F2: begin
          r_state <= S_W2;
        end
        S_W2: begin
          if (lc_done) begin
            unique case (1'b1)
              w_is_xor: begin
                label_store   <= r_lab1 ^ lc_label;
                wire_id_write <= r_out;
                store_strobe  <= 1'b1;
                r_state       <= S_ST;
              end
              w_is_and: begin
                eval_label <= lc_label;
                eval_ptr   <= lc_ptr;
                eval_req   <= 1'b1;
                r_state    <= S_EV;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_EV: begin
          r_state <= S_WEV;
        end
        S_WEV: begin
          if (eval_done) begin
            label_store   <= eval_result;
            wire_id_write <= r_out;
            store_strobe  <= 1'b1;
            r_state       <= S_ST;
          end
        end
        S_ST: begin
          r_state <= S_WST;
        end
        S_WST: begin
          if (lc_done) begin
            r_cnt    <= w_cnt_inc;
            gd_ready <= (w_cnt_inc != r_num);
            r_state  <= S_NEXT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq.sv
// Self-checking bench for gate_seq with label-controller and evaluator models.
module tb_gate_seq;
  import gc_pkg::*;

  localparam int W = 24;
  localparam int L = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num_gates = '0;
  logic         busy, circuit_done, err_gate;
  logic         gd_valid = 1'b0;
  logic         gd_ready;
  logic [1:0]   gd_type = '0;
  logic [W-1:0] gd_in1 = '0, gd_in2 = '0, gd_out = '0;
  logic [W-1:0] wire_id_read;
  logic         id_1_strobe, id_2_strobe;
  logic [1:0]   gate_type;
  logic         lc_done = 1'b0;
  logic [L-1:0] lc_label = '0;
  logic [1:0]   lc_ptr = '0;
  logic [W-1:0] wire_id_write;
  logic         store_strobe;
  logic [L-1:0] label_store;
  logic         eval_req;
  logic [L-1:0] eval_label;
  logic [1:0]   eval_ptr;
  logic         eval_done = 1'b0;
  logic [L-1:0] eval_result = '0;
  logic         lc_rst;

  always #5 clk = ~clk;

  gate_seq #(.WIRE_ID_W(W), .LABEL_W(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_gates(num_gates),
    .busy(busy), .circuit_done(circuit_done), .err_gate(err_gate),
    .gd_valid(gd_valid), .gd_ready(gd_ready), .gd_type(gd_type),
    .gd_in1(gd_in1), .gd_in2(gd_in2), .gd_out(gd_out),
    .wire_id_read(wire_id_read), .id_1_strobe(id_1_strobe),
    .id_2_strobe(id_2_strobe), .gate_type(gate_type),
    .lc_done(lc_done), .lc_label(lc_label), .lc_ptr(lc_ptr),
    .wire_id_write(wire_id_write), .store_strobe(store_strobe),
    .label_store(label_store), .eval_req(eval_req),
    .eval_label(eval_label), .eval_ptr(eval_ptr),
    .eval_done(eval_done), .eval_result(eval_result), .lc_rst(lc_rst)
  );

  localparam int K_ID1 = 1, K_ID2 = 2, K_EVAL = 3, K_STORE = 4, K_DONE = 5;

  typedef struct {
    int           kind;
    logic [W-1:0] id;
    logic [L-1:0] lab;
    logic [1:0]   ptr;
    logic [1:0]   gt;
  } ev_t;

  ev_t expq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_busy = 0;
  bit m_err = 0;
  logic [1:0]   m_ptr = '0;
  logic [L-1:0] m_evres = '0;
  int lc_dly = 2;
  int ev_dly = 3;
  bit spur = 0;

  int n_store = 0, n_eval = 0, n_id2 = 0, n_rdy = 0;
  int st_cyc = 0, ev_cyc = 0;
  logic [L-1:0] last_store_lab = '0;
  logic [W-1:0] last_store_id = '0;
  logic [1:0]   last_eval_ptr = '0;

  function automatic logic [L-1:0] lab(input logic [W-1:0] id);
    logic [7:0] b;
    b = id[7:0] ^ 8'h3C;
    return {16{b}};
  endfunction

  task automatic chk(input string name, input logic [L-1:0] act,
                     input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Label controller and AND evaluator behaviour.
  int lcn = 0, evn = 0;
  logic [L-1:0] lpend = '0;
  always @(negedge clk) begin
    lc_done = 1'b0;
    eval_done = 1'b0;
    lc_label = '1;
    lc_ptr = ~m_ptr;
    if (!rst_n) begin
      lcn = 0;
      evn = 0;
    end else begin
      if (spur) begin
        lc_done = 1'b1;
        eval_done = 1'b1;
        spur = 0;
      end
      if (lcn != 0) begin
        lcn--;
        if (lcn == 0) begin
          lc_done = 1'b1;
          lc_label = lpend;
          lc_ptr = m_ptr;
        end
      end
      if (evn != 0) begin
        evn--;
        if (evn == 0) begin
          eval_done = 1'b1;
          eval_result = m_evres;
          ev_cyc = cyc;
        end
      end
      if (id_1_strobe || id_2_strobe) begin
        lcn = lc_dly;
        lpend = lab(wire_id_read);
      end
      if (store_strobe) begin
        lcn = lc_dly;
        lpend = '0;
      end
      if (eval_req) evn = ev_dly;
    end
  end

  task automatic take(input int k, input logic [W-1:0] id,
                      input logic [L-1:0] lb, input logic [1:0] p);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d id %h expected none", k, id);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", L'(k), L'(e.kind));
    if (k != e.kind) return;
    case (k)
      K_ID1, K_ID2: begin
        chk("fetch_id", L'(id), L'(e.id));
        chk("gate_type", L'(gate_type), L'(e.gt));
      end
      K_EVAL: begin
        chk("eval_label", lb, e.lab);
        chk("eval_ptr", L'(p), L'(e.ptr));
      end
      K_STORE: begin
        chk("store_id", L'(id), L'(e.id));
        chk("store_label", lb, e.lab);
      end
      default: m_busy = 0;
    endcase
  endtask

  logic p1 = 0, p2 = 0, ps = 0, pe = 0, pd = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("single_pulse",
          L'({id_1_strobe & p1, id_2_strobe & p2, store_strobe & ps,
              eval_req & pe, circuit_done & pd}), '0);
      if (id_1_strobe) take(K_ID1, wire_id_read, '0, '0);
      if (id_2_strobe) begin
        n_id2++;
        take(K_ID2, wire_id_read, '0, '0);
      end
      if (eval_req) begin
        n_eval++;
        last_eval_ptr = eval_ptr;
        take(K_EVAL, '0, eval_label, eval_ptr);
      end
      if (store_strobe) begin
        n_store++;
        st_cyc = cyc;
        last_store_lab = label_store;
        last_store_id = wire_id_write;
        take(K_STORE, wire_id_write, label_store, '0);
      end
      if (circuit_done) take(K_DONE, '0, '0, '0);
      if (gd_ready) n_rdy++;
      chk("busy", L'(busy), L'(m_busy));
      chk("err_gate", L'(err_gate), L'(m_err));
      if (!m_busy) chk("gd_ready_idle", L'(gd_ready), '0);
    end
    p1 = id_1_strobe; p2 = id_2_strobe; ps = store_strobe;
    pe = eval_req; pd = circuit_done;
  end

  function automatic ev_t mk(input int k, input logic [W-1:0] id,
                             input logic [L-1:0] lb, input logic [1:0] p,
                             input logic [1:0] g);
    ev_t e;
    e.kind = k; e.id = id; e.lab = lb; e.ptr = p; e.gt = g;
    return e;
  endfunction

  task automatic expect_done();
    expq.push_back(mk(K_DONE, '0, '0, '0, '0));
  endtask

  task automatic do_start(input logic [W-1:0] n);
    @(negedge clk);
    start = 1'b1;
    num_gates = n;
    m_busy = 1;
    @(negedge clk);
    start = 1'b0;
    num_gates = '1;
  endtask

  task automatic send_gate(input logic [1:0] t, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] o);
    int n;
    logic [L-1:0] sl;
    n = 0;
    @(negedge clk);
    while (!gd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!gd_ready) begin
      checks++;
      errors++;
      $display("FAIL gd_ready_timeout: got 0 expected 1");
      return;
    end
    if (t == BAD_GATE) begin
      m_err = 1;
    end else begin
      expq.push_back(mk(K_ID1, a, '0, '0, t));
      if (t != BUF_GATE) expq.push_back(mk(K_ID2, b, '0, '0, t));
      if (t == AND_GATE) expq.push_back(mk(K_EVAL, '0, lab(b), m_ptr, t));
      if (t == BUF_GATE) sl = lab(a);
      else if (t == XOR_GATE) sl = lab(a) ^ lab(b);
      else sl = m_evres;
      expq.push_back(mk(K_STORE, o, sl, '0, t));
    end
    gd_valid = 1'b1;
    gd_type = t; gd_in1 = a; gd_in2 = b; gd_out = o;
    @(negedge clk);
    gd_valid = 1'b0;
    gd_type = 2'($urandom); gd_in1 = '1; gd_in2 = '1; gd_out = '1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", L'(m_busy), '0);
    chk("queue_empty", L'(expq.size()), '0);
  endtask

  task automatic chk_cleared();
    chk("rst_busy", L'(busy), '0);
    chk("rst_err", L'(err_gate), '0);
    chk("rst_done_rdy", L'({circuit_done, gd_ready}), '0);
    chk("rst_pulses",
        L'({id_1_strobe, id_2_strobe, store_strobe, eval_req}), '0);
    chk("rst_ids", L'({wire_id_read, wire_id_write, gate_type}), '0);
    chk("rst_label_store", label_store, '0);
    chk("rst_eval", eval_label | L'(eval_ptr), '0);
  endtask

  int s0, e0, i0, r0, n;

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared();
    chk("lc_rst_in_reset", L'(lc_rst), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("lc_rst_released", L'(lc_rst), 0);

    // Empty circuit; stray done pulses must be ignored.
    spur = 1;
    repeat (2) @(negedge clk);
    r0 = n_rdy;
    expect_done();
    do_start(0);
    wait_done();
    chk("zero_gates_no_ready", L'(n_rdy - r0), 0);

    // Single XOR gate, with a start pulse while busy.
    m_ptr = 2'b01;
    lc_dly = 2;
    e0 = n_eval;
    do_start(1);
    send_gate(XOR_GATE, 5, 9, 12);
    start = 1'b1;
    num_gates = 7;
    @(negedge clk);
    start = 1'b0;
    expect_done();
    wait_done();
    chk("xor_label_lit", last_store_lab, {16{8'h0C}});
    chk("xor_store_id_lit", L'(last_store_id), 12);
    chk("xor_no_eval", L'(n_eval - e0), 0);

    // Single AND gate with slow evaluator.
    m_ptr = 2'b10;
    m_evres = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    ev_dly = 7;
    lc_dly = 3;
    e0 = n_eval;
    do_start(1);
    send_gate(AND_GATE, 7, 8, 20);
    expect_done();
    wait_done();
    chk("and_eval_once", L'(n_eval - e0), 1);
    chk("and_ptr_lit", L'(last_eval_ptr), 2'b10);
    chk("and_label_lit", last_store_lab,
        128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    chk("and_store_latency", L'(st_cyc - ev_cyc), 1);

    // BUF gate.
    lc_dly = 1;
    i0 = n_id2;
    do_start(1);
    send_gate(BUF_GATE, 3, 0, 4);
    expect_done();
    wait_done();
    chk("buf_no_id2", L'(n_id2 - i0), 0);
    chk("buf_label_lit", last_store_lab, {16{8'h3F}});
    chk("buf_store_id_lit", L'(last_store_id), 4);

    // Invalid gate in the middle of three.
    lc_dly = 2;
    ev_dly = 2;
    s0 = n_store;
    do_start(3);
    send_gate(XOR_GATE, 1, 2, 3);
    send_gate(BAD_GATE, 6, 6, 6);
    send_gate(AND_GATE, 4, 5, 6);
    expect_done();
    wait_done();
    chk("bad_err_sticky", L'(err_gate), 1);
    chk("bad_two_stores", L'(n_store - s0), 2);

    // Reset while waiting on the evaluator.
    ev_dly = 20;
    e0 = n_eval;
    do_start(1);
    send_gate(AND_GATE, 10, 11, 12);
    n = 0;
    while (n_eval == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wev_reached", L'(n_eval - e0), 1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared();
    expq.delete();
    m_busy = 0;
    m_err = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_store;
    repeat (30) @(negedge clk);
    chk("no_store_after_rst", L'(n_store - s0), 0);
    ev_dly = 3;
    do_start(2);
    send_gate(XOR_GATE, 21, 22, 23);
    send_gate(BUF_GATE, 24, 0, 25);
    expect_done();
    wait_done();
    chk("post_rst_stores", L'(n_store - s0), 2);
    chk("post_rst_err_clear", L'(err_gate), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
